regbank_rw: RTL and testbench

Parametrised register bank for the CPU datapath: DEPTH registers of WIDTH bits, one synchronous write port and two independent registered read ports (A, B) with same-cycle write-to-read forwarding, a pipeline hold input and an optional hardwired-zero register. It replaces the flat 16-to-1 combinational register select. Read data feeds the ALU operand latches one cycle after the address is presented.

---
 rtl/regbank_pkg.sv | 25 ++
 rtl/regbank_rw_if.sv | 28 ++
 rtl/regbank_rdport.sv | 61 ++++++
 rtl/regbank_rw.sv | 79 +++++++
 tb/tb_regbank_rw.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank: default geometry, address-width
// helper and the read-port request type.
package regbank_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam int MAX_AW    = 8;

  function automatic int addr_width(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

  // Read request carried to each port; address is widened to the largest legal AW.
  typedef struct packed {
    logic              re;
    logic [MAX_AW-1:0] raddr;
  } rd_req_t;

endpackage

// File: rtl/regbank_rw_if.sv
// Bus bundle of the register bank: write port, hold, and two read ports.
interface regbank_rw_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             hold;
  logic             re_a;
  logic             re_b;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             rvalid_a;
  logic             rvalid_b;

  modport master (
    output we, waddr, wdata, hold, re_a, re_b, raddr_a, raddr_b,
    input  rdata_a, rdata_b, rvalid_a, rvalid_b
  );

  modport slave (
    input  we, waddr, wdata, hold, re_a, re_b, raddr_a, raddr_b,
    output rdata_a, rdata_b, rvalid_a, rvalid_b
  );
endinterface

// File: rtl/regbank_rdport.sv
// One registered read port: range check, hardwired zero, write forwarding
// and the rdata/rvalid output registers.
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  rd_req_t           req,
  input  logic              wr_en,
  input  logic [MAX_AW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [WIDTH-1:0]  mem [DEPTH],
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid
);
  localparam int AW = addr_width(DEPTH);

  logic [WIDTH-1:0] sel_s;
  logic [WIDTH-1:0] rdata_r;
  logic             rvalid_r;

  // Read value selection; wr_en arrives already qualified, so forwarding never bypasses an ignored write.
  always_comb begin
    sel_s = '0;
    if (int'(req.raddr) >= DEPTH) begin
      sel_s = '0;
    end else if ((ZERO_REG != 0) && (req.raddr == '0)) begin
      sel_s = '0;
    end else if (wr_en && (waddr == req.raddr)) begin
      sel_s = wdata;
    end else begin
      sel_s = mem[req.raddr[AW-1:0]];
    end
  end

  // Output registers: reset wins over hold, hold freezes both, idle drops rvalid only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else if (hold) begin
      rdata_r  <= rdata_r;
      rvalid_r <= rvalid_r;
    end else if (req.re) begin
      rdata_r  <= sel_s;
      rvalid_r <= 1'b1;
    end else begin
      rdata_r  <= rdata_r;
      rvalid_r <= 1'b0;
    end
  end

  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;

endmodule

// File: rtl/regbank_rw.sv
// Register bank top: DEPTH x WIDTH storage with one write port and two
// independent registered read ports.
module regbank_rw
  import regbank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0
) (
  input logic         clk,
  input logic         rst,
  regbank_rw_if.slave bus
);
  localparam int AW = addr_width(DEPTH);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic              wr_en_s;
  logic [MAX_AW-1:0] waddr_s;
  rd_req_t           req_a_s;
  rd_req_t           req_b_s;

  // Qualify the write: out-of-range and hardwired-zero targets are dropped.
  always_comb begin
    wr_en_s = 1'b0;
    if (!bus.we) begin
      wr_en_s = 1'b0;
    end else if (int'(bus.waddr) >= DEPTH) begin
      wr_en_s = 1'b0;
    end else if ((ZERO_REG != 0) && (bus.waddr == '0)) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = 1'b1;
    end
  end

  assign waddr_s = MAX_AW'(bus.waddr);
  assign req_a_s = '{re: bus.re_a, raddr: MAX_AW'(bus.raddr_a)};
  assign req_b_s = '{re: bus.re_b, raddr: MAX_AW'(bus.raddr_b)};

  // Storage array; a write coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[bus.waddr[AW-1:0]] <= bus.wdata;
    end else begin
      mem_r <= mem_r;
    end
  end

  regbank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_port_a (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.hold),
    .req    (req_a_s),
    .wr_en  (wr_en_s),
    .waddr  (waddr_s),
    .wdata  (bus.wdata),
    .mem    (mem_r),
    .rdata  (bus.rdata_a),
    .rvalid (bus.rvalid_a)
  );

  regbank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_port_b (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.hold),
    .req    (req_b_s),
    .wr_en  (wr_en_s),
    .waddr  (waddr_s),
    .wdata  (bus.wdata),
    .mem    (mem_r),
    .rdata  (bus.rdata_b),
    .rvalid (bus.rvalid_b)
  );

endmodule

// File: tb/tb_regbank_rw.sv
// Scoreboard bench for regbank_rw: three instances (plain, ZERO_REG=1, DEPTH=12)
// driven in lockstep and compared cycle by cycle against a behavioural model.
module tb_regbank_rw;

  typedef struct packed {
    logic [31:0] rda;
    logic        rva;
    logic [31:0] rdb;
    logic        rvb;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        hold;
  logic        re_a;
  logic        re_b;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  obs_t        act_s [3];

  int n_tests = 0;
  int n_fail  = 0;

  obs_t exp_q [$];
  obs_t act_q [$];

  logic [31:0] mreg [3][16];
  logic [31:0] m_rda [3];
  logic [31:0] m_rdb [3];
  logic        m_rva [3];
  logic        m_rvb [3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    regbank_rw_if #(.WIDTH(32), .AW(4)) bus ();
    assign bus.we      = we;
    assign bus.waddr   = waddr;
    assign bus.wdata   = wdata;
    assign bus.hold    = hold;
    assign bus.re_a    = re_a;
    assign bus.re_b    = re_b;
    assign bus.raddr_a = raddr_a;
    assign bus.raddr_b = raddr_b;
    regbank_rw #(.WIDTH(32), .DEPTH((k == 2) ? 12 : 16), .ZERO_REG((k == 1) ? 1 : 0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign act_s[k] = '{rda: bus.rdata_a, rva: bus.rvalid_a, rdb: bus.rdata_b, rvb: bus.rvalid_b};
  end

  function automatic logic [31:0] model_read(input int k, input logic [3:0] ra, input logic wok);
    int depth;
    depth = (k == 2) ? 12 : 16;
    if (int'(ra) >= depth) return 32'h0;
    if ((k == 1) && (ra == 4'd0)) return 32'h0;
    if (wok && (waddr == ra)) return wdata;
    return mreg[k][ra];
  endfunction

  // Advance one clock: predict all three instances, then record what they produced.
  task automatic step();
    for (int k = 0; k < 3; k++) begin
      int   depth;
      logic wok;
      depth = (k == 2) ? 12 : 16;
      wok = we && (int'(waddr) < depth) && !((k == 1) && (waddr == 4'd0));
      if (rst) begin
        for (int i = 0; i < 16; i++) mreg[k][i] = 32'h0;
        m_rda[k] = 32'h0; m_rva[k] = 1'b0;
        m_rdb[k] = 32'h0; m_rvb[k] = 1'b0;
      end else begin
        if (!hold) begin
          if (re_a) begin m_rda[k] = model_read(k, raddr_a, wok); m_rva[k] = 1'b1; end
          else m_rva[k] = 1'b0;
          if (re_b) begin m_rdb[k] = model_read(k, raddr_b, wok); m_rvb[k] = 1'b1; end
          else m_rvb[k] = 1'b0;
        end
        if (wok) mreg[k][waddr] = wdata;
      end
      exp_q.push_back('{rda: m_rda[k], rva: m_rva[k], rdb: m_rdb[k], rvb: m_rvb[k]});
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) act_q.push_back(act_s[k]);
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = 4'd0; wdata = 32'h0; hold = 1'b0;
    re_a = 1'b0; re_b = 1'b0; raddr_a = 4'd0; raddr_b = 4'd0;
  endtask

  task automatic test_reset();
    obs_t e, a;
    rst = 1'b1; idle_inputs(); hold = 1'b1;
    step();
    rst = 1'b0; hold = 1'b0; we = 1'b1; waddr = 4'd3; wdata = 32'hDEAD_BEEF;
    step();
    we = 1'b0; rst = 1'b1; re_a = 1'b1; raddr_a = 4'd3;
    step();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (act_s[k] !== 65'h0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d: got %h want 0", k, act_s[k]);
      end
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (act_s[0].rda !== 32'h0 || act_s[0].rva !== 1'b1) begin
      n_fail++; $display("FAIL reset_clears_reg3: got %h/%b want 00000000/1", act_s[0].rda, act_s[0].rva);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL reset_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_write_read();
    obs_t e, a;
    idle_inputs(); we = 1'b1; waddr = 4'd5; wdata = 32'h1234_5678;
    step();
    idle_inputs(); re_a = 1'b1; re_b = 1'b1; raddr_a = 4'd5; raddr_b = 4'd5;
    step();
    n_tests++;
    if (act_s[0].rda !== 32'h1234_5678 || act_s[0].rdb !== 32'h1234_5678 ||
        act_s[0].rva !== 1'b1 || act_s[0].rvb !== 1'b1) begin
      n_fail++; $display("FAIL write_read: got %h want A=B=12345678 valid", act_s[0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL write_read_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_forward();
    obs_t e, a;
    idle_inputs(); we = 1'b1; waddr = 4'd7; wdata = 32'hA5A5_0001; re_a = 1'b1; raddr_a = 4'd7;
    step();
    n_tests++;
    if (act_s[0].rda !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL forward_a: got %h want a5a50001", act_s[0].rda);
    end
    idle_inputs(); re_b = 1'b1; raddr_b = 4'd7;
    step();
    n_tests++;
    if (act_s[0].rdb !== 32'hA5A5_0001 || act_s[0].rva !== 1'b0) begin
      n_fail++; $display("FAIL forward_b: got %h/%b want a5a50001/0", act_s[0].rdb, act_s[0].rva);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL forward_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_zero_reg();
    obs_t e, a;
    idle_inputs(); we = 1'b1; waddr = 4'd0; wdata = 32'hFFFF_FFFF; re_a = 1'b1; raddr_a = 4'd0;
    step();
    n_tests++;
    if (act_s[1].rda !== 32'h0 || act_s[0].rda !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL zero_fwd: got z=%h p=%h want 0/ffffffff", act_s[1].rda, act_s[0].rda);
    end
    idle_inputs(); re_b = 1'b1; raddr_b = 4'd0;
    step();
    n_tests++;
    if (act_s[1].rdb !== 32'h0 || act_s[1].rvb !== 1'b1) begin
      n_fail++; $display("FAIL zero_later: got %h/%b want 0/1", act_s[1].rdb, act_s[1].rvb);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL zero_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_hold();
    obs_t e, a;
    idle_inputs(); we = 1'b1; waddr = 4'd2; wdata = 32'h11;
    step();
    idle_inputs(); re_a = 1'b1; raddr_a = 4'd2;
    step();
    hold = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 32'h22;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (act_s[0].rda !== 32'h11 || act_s[0].rva !== 1'b1) begin
        n_fail++; $display("FAIL hold_c%0d: got %h/%b want 00000011/1", c, act_s[0].rda, act_s[0].rva);
      end
    end
    hold = 1'b0; we = 1'b0;
    step();
    n_tests++;
    if (act_s[0].rda !== 32'h22) begin
      n_fail++; $display("FAIL hold_release: got %h want 00000022", act_s[0].rda);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL hold_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_depth12();
    obs_t e, a;
    idle_inputs(); we = 1'b1; waddr = 4'd13; wdata = 32'h55;
    step();
    idle_inputs(); re_a = 1'b1; raddr_a = 4'd13;
    step();
    n_tests++;
    if (act_s[2].rda !== 32'h0 || act_s[2].rva !== 1'b1 || act_s[0].rda !== 32'h55) begin
      n_fail++; $display("FAIL depth12_oor: got d12=%h/%b d16=%h want 0/1 and 55",
                         act_s[2].rda, act_s[2].rva, act_s[0].rda);
    end
    for (int i = 0; i < 12; i++) begin
      raddr_a = 4'(i); raddr_b = 4'(11 - i); re_b = 1'b1;
      step();
    end
    raddr_a = 4'd5; re_b = 1'b0;
    step();
    re_a = 1'b0;
    step();
    n_tests++;
    if (act_s[2].rva !== 1'b0 || act_s[2].rda !== 32'h1234_5678) begin
      n_fail++; $display("FAIL depth12_idle: got %h/%b want 12345678/0", act_s[2].rda, act_s[2].rva);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL depth12_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_mid_reset();
    obs_t e, a;
    idle_inputs(); re_a = 1'b1; raddr_a = 4'd5;
    step();
    rst = 1'b1; hold = 1'b1;
    step();
    rst = 1'b0; hold = 1'b0; re_a = 1'b0;
    step();
    n_tests++;
    if (act_s[0].rda !== 32'h0 || act_s[0].rva !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_drop: got %h/%b want 0/0", act_s[0].rda, act_s[0].rva);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL mid_reset_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    for (int c = 0; c < 300; c++) begin
      rst     = ($urandom_range(0, 31) == 0);
      hold    = ($urandom_range(0, 5) == 0);
      we      = 1'($urandom_range(0, 1));
      waddr   = 4'($urandom_range(0, 15));
      wdata   = $urandom;
      re_a    = ($urandom_range(0, 3) != 0);
      re_b    = ($urandom_range(0, 3) != 0);
      raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr_b = ($urandom_range(0, 2) == 0) ? raddr_a : 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL b2b_sb: got %h want %h", a, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      m_rda[k] = 32'h0; m_rdb[k] = 32'h0; m_rva[k] = 1'b0; m_rvb[k] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_forward();
    test_zero_reg();
    test_hold();
    test_depth12();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
